// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 cache with 128-bit lines.
// Hits complete combinationally in IDLE; misses run a victim write-back and/or line fetch.
module l2_cache #(
    parameter int SET_BITS   = 4,
    parameter int NUM_OF_SET = 1 << SET_BITS,
    parameter int TAG_W      = 28 - SET_BITS
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         l1_read,
    input  logic         l1_write,
    input  logic [29:0]  l1_addr,
    input  logic [127:0] l1_wdata,
    output logic [127:0] l1_rdata,
    output logic         l1_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

    state_t               state;
    logic [127:0]         data  [NUM_OF_SET];
    logic [TAG_W-1:0]     tags  [NUM_OF_SET];
    logic [NUM_OF_SET-1:0] valid;
    logic [NUM_OF_SET-1:0] dirty;

    // Miss context is latched so the memory transaction survives L1 request changes.
    logic [27:0]          miss_line;
    logic                 miss_rd;

    logic [SET_BITS-1:0]  idx;
    logic [TAG_W-1:0]     tag;
    logic                 rd;
    logic                 wr;
    logic                 hit;
    logic                 victim_dirty;
    logic [SET_BITS-1:0]  miss_idx;
    logic [TAG_W-1:0]     miss_tag;
    logic                 unused_bits;

    assign idx          = l1_addr[SET_BITS+1:2];
    assign tag          = l1_addr[29:SET_BITS+2];
    assign rd           = l1_read & ~l1_write;
    assign wr           = l1_write & ~l1_read;
    assign hit          = valid[idx] && (tags[idx] == tag);
    assign victim_dirty = valid[idx] & dirty[idx];
    assign miss_idx     = miss_line[SET_BITS-1:0];
    assign miss_tag     = miss_line[27:SET_BITS];
    assign unused_bits  = ^l1_addr[1:0];

    always_comb begin
        l1_ready = 1'b0;
        l1_rdata = '0;
        if (!proc_reset && state == IDLE) begin
            if (rd && hit) begin
                l1_ready = 1'b1;
                l1_rdata = data[idx];
            end else if (wr && (hit || !victim_dirty)) begin
                l1_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            miss_line <= '0;
            miss_rd   <= 1'b0;
            for (int i = 0; i < NUM_OF_SET; i++) begin
                data[i] <= '0;
                tags[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr && (hit || !victim_dirty)) begin
                        data[idx]  <= l1_wdata;
                        tags[idx]  <= tag;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b1;
                    end else if ((rd || wr) && !hit) begin
                        miss_line <= l1_addr[29:2];
                        miss_rd   <= rd;
                        if (victim_dirty) begin
                            state     <= WB;
                            mem_write <= 1'b1;
                            mem_addr  <= {tags[idx], idx};
                            mem_wdata <= data[idx];
                        end else begin
                            state    <= ALLOC;
                            mem_read <= 1'b1;
                            mem_addr <= l1_addr[29:2];
                        end
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        mem_write       <= 1'b0;
                        mem_wdata       <= '0;
                        valid[miss_idx] <= 1'b0;
                        dirty[miss_idx] <= 1'b0;
                        if (miss_rd) begin
                            state    <= ALLOC;
                            mem_read <= 1'b1;
                            mem_addr <= miss_line;
                        end else begin
                            state    <= IDLE;
                            mem_addr <= '0;
                        end
                    end
                end
                ALLOC: begin
                    if (mem_ready) begin
                        data[miss_idx]  <= mem_rdata;
                        tags[miss_idx]  <= miss_tag;
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        state           <= IDLE;
                        mem_read        <= 1'b0;
                        mem_addr        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
